// File: rtl/acc_26x34_row_pkg.sv
// Shared widths for the 26x34 multiplier datapath and its row accumulator.
// The multiplier pipeline imports the same constants.
package acc_26x34_row_pkg;

    localparam int LIMB_W  = 34;
    localparam int A_W     = 26;
    localparam int P_W     = 60;
    localparam int CARRY_W = P_W - LIMB_W;

    function automatic int c_width(input int num_limbs);
        return A_W + LIMB_W * num_limbs;
    endfunction

endpackage

// File: rtl/acc_26x34_cstep.sv
// One carry-propagate step: s = p + cr, split into the finalised limb and the carry.
// Purely combinational; the sum cannot overflow P_W bits.
module acc_26x34_cstep
    import acc_26x34_row_pkg::*;
(
    input  logic [P_W-1:0]     p_i,
    input  logic [CARRY_W-1:0] cr_i,
    output logic [P_W-1:0]     s_o,
    output logic [LIMB_W-1:0]  limb_o,
    output logic [CARRY_W-1:0] carry_o
);

    always_comb begin
        s_o     = p_i + {{LIMB_W{1'b0}}, cr_i};
        limb_o  = s_o[LIMB_W-1:0];
        carry_o = s_o[P_W-1:LIMB_W];
    end

endmodule

// File: rtl/acc_26x34_row.sv
// Streaming shift-accumulate of A*B_i partial products into the full row product.
// One limb finalised per accepted product; always ready, result held until the next completion.
module acc_26x34_row
    import acc_26x34_row_pkg::*;
#(
    parameter int NUM_LIMBS = 4,
    parameter bit FF_OUT    = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic [P_W-1:0]                  in_p,
    input  logic                            in_clr,
    output logic                            out_valid,
    output logic [c_width(NUM_LIMBS)-1:0]   out_c,
    output logic                            busy
);

    localparam int C_W  = c_width(NUM_LIMBS);
    localparam int LO_W = LIMB_W * (NUM_LIMBS - 1);
    localparam int K_W  = $clog2(NUM_LIMBS);
    localparam logic [K_W-1:0] LAST_K = K_W'(NUM_LIMBS - 1);

    logic [K_W-1:0]     k_q, k_d, k_eff;
    logic [CARRY_W-1:0] cr_q, cr_d, cr_in;
    logic [LO_W-1:0]    lo_q, lo_d;
    logic [C_W-1:0]     res_q, res_d;
    logic [P_W-1:0]     s;
    logic [LIMB_W-1:0]  limb;
    logic [CARRY_W-1:0] carry;
    logic               done;

    // A clear arriving with a product restarts the row at this product.
    always_comb begin
        k_eff = in_clr ? '0 : k_q;
        cr_in = (k_eff == '0) ? '0 : cr_q;
        done  = in_valid && (k_eff == LAST_K) && rst;
    end

    acc_26x34_cstep u_cstep (
        .p_i     (in_p),
        .cr_i    (cr_in),
        .s_o     (s),
        .limb_o  (limb),
        .carry_o (carry)
    );

    generate
        if (NUM_LIMBS > 2) begin : g_lo_wide
            always_comb lo_d = {limb, lo_q[LO_W-1:LIMB_W]};
        end else begin : g_lo_one
            always_comb lo_d = limb;
        end
    endgenerate

    always_comb begin
        k_d   = k_q;
        cr_d  = cr_q;
        res_d = res_q;
        if (in_valid) begin
            if (k_eff == LAST_K) begin
                k_d   = '0;
                cr_d  = '0;
                res_d = {s, lo_q};
            end else begin
                k_d  = k_eff + K_W'(1);
                cr_d = carry;
            end
        end else if (in_clr) begin
            k_d  = '0;
            cr_d = '0;
        end
    end

    // lo holds stale limbs after a clear; they are shifted out before the next completion.
    always_ff @(posedge clk) begin
        if (!rst) begin
            k_q   <= '0;
            cr_q  <= '0;
            lo_q  <= '0;
            res_q <= '0;
        end else begin
            k_q   <= k_d;
            cr_q  <= cr_d;
            res_q <= res_d;
            if (in_valid && (k_eff != LAST_K)) begin
                lo_q <= lo_d;
            end
        end
    end

    assign busy = (k_q != '0);

    generate
        if (FF_OUT) begin : g_ff_out
            logic out_valid_q;
            always_ff @(posedge clk) begin
                if (!rst) begin
                    out_valid_q <= 1'b0;
                end else begin
                    out_valid_q <= done;
                end
            end
            assign out_valid = out_valid_q;
            assign out_c     = res_q;
        end else begin : g_comb_out
            assign out_valid = done;
            assign out_c     = done ? {s, lo_q} : res_q;
        end
    endgenerate

endmodule

// File: tb/tb_acc_26x34_row.sv
// Directed checks of the row accumulator at NUM_LIMBS = 4, registered outputs.
module tb_acc_26x34_row;

    localparam int CW = 162;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [59:0]   in_p;
    logic          in_clr;
    logic          out_valid;
    logic [CW-1:0] out_c;
    logic          busy;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    acc_26x34_row #(.NUM_LIMBS(4), .FF_OUT(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_p      (in_p),
        .in_clr    (in_clr),
        .out_valid (out_valid),
        .out_c     (out_c),
        .busy      (busy)
    );

    always @(negedge clk) if (out_valid === 1'b1) pulses++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [59:0] p);
        in_valid = 1'b1;
        in_p     = p;
        tick();
        in_valid = 1'b0;
        in_p     = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [CW-1:0] exp1, expmax, exp9, expclr, amax, sh136;
    logic [59:0]   pmax;
    int            p0;

    initial begin
        exp1   = CW'(1) + (CW'(2) << 34) + (CW'(3) << 68) + (CW'(4) << 102);
        amax   = (CW'(1) << 26) - CW'(1);
        sh136  = (CW'(1) << 136) - CW'(1);
        expmax = amax * sh136;
        pmax   = 60'((((CW'(1) << 26) - 1)) * ((CW'(1) << 34) - 1));
        exp9   = CW'(9) * (CW'(1) + (CW'(1) << 34) + (CW'(1) << 68) + (CW'(1) << 102));
        expclr = CW'(7) + (CW'(1) << 34) + (CW'(1) << 68) + (CW'(1) << 102);

        rst = 1'b0; in_valid = 1'b0; in_p = '0; in_clr = 1'b0;
        idle(2);
        check("rst_valid", CW'(out_valid), CW'(0));
        check("rst_c", out_c, CW'(0));
        check("rst_busy", CW'(busy), CW'(0));
        rst = 1'b1;
        idle(1);

        // Scenario 1: 1,2,3,4 gap-free
        send(60'd1); check("s1_busy1", CW'(busy), CW'(1));
        send(60'd2); check("s1_busy2", CW'(busy), CW'(1));
        send(60'd3); check("s1_busy3", CW'(busy), CW'(1));
        check("s1_novalid", CW'(out_valid), CW'(0));
        send(60'd4);
        check("s1_valid", CW'(out_valid), CW'(1));
        check("s1_c", out_c, exp1);
        check("s1_busy_end", CW'(busy), CW'(0));
        idle(1);
        check("s1_pulse_end", CW'(out_valid), CW'(0));
        check("s1_hold", out_c, exp1);

        // Scenario 2: full carry propagation
        for (int i = 0; i < 4; i++) send(pmax);
        check("s2_valid", CW'(out_valid), CW'(1));
        check("s2_c", out_c, expmax);
        idle(1);

        // Scenario 3: gaps inside the row
        p0 = pulses;
        send(60'd5); idle(0);
        send(60'd6); idle(3);
        send(60'd7); idle(1);
        send(60'd8);
        check("s3_c", out_c, CW'(5) + (CW'(6) << 34) + (CW'(7) << 68) + (CW'(8) << 102));
        idle(3);
        check("s3_pulses", CW'(pulses - p0), CW'(1));

        // Scenario 4: back-to-back rows
        send(60'd1); send(60'd2); send(60'd3); send(60'd4);
        check("s4_valid1", CW'(out_valid), CW'(1));
        check("s4_c1", out_c, exp1);
        send(60'd9);
        check("s4_gap", CW'(out_valid), CW'(0));
        send(60'd9); send(60'd9); send(60'd9);
        check("s4_valid2", CW'(out_valid), CW'(1));
        check("s4_c2", out_c, exp9);
        idle(1);

        // Scenario 5: clear with a product restarts the row
        send(60'd5); send(60'd5);
        in_clr = 1'b1; send(60'd7); in_clr = 1'b0;
        check("s5_busy", CW'(busy), CW'(1));
        send(60'd1); send(60'd1);
        check("s5_early", CW'(out_valid), CW'(0));
        send(60'd1);
        check("s5_valid", CW'(out_valid), CW'(1));
        check("s5_c", out_c, expclr);
        idle(1);

        // Idle clear drops the partial row and keeps out_c
        send(60'd3);
        in_clr = 1'b1; tick(); in_clr = 1'b0;
        check("clr_busy", CW'(busy), CW'(0));
        check("clr_valid", CW'(out_valid), CW'(0));
        check("clr_hold", out_c, expclr);

        // Scenario 6: reset mid-row
        p0 = pulses;
        send(60'd1); send(60'd2);
        rst = 1'b0; tick(); rst = 1'b1;
        check("s6_rst_c", out_c, CW'(0));
        check("s6_rst_busy", CW'(busy), CW'(0));
        send(60'd1); send(60'd2); send(60'd3); send(60'd4);
        check("s6_c", out_c, exp1);
        idle(2);
        check("s6_pulses", CW'(pulses - p0), CW'(1));

        // Reset coincident with the last limb wins
        send(60'd1); send(60'd2); send(60'd3);
        rst = 1'b0; send(60'd4); rst = 1'b1;
        check("rlast_valid", CW'(out_valid), CW'(0));
        check("rlast_c", out_c, CW'(0));
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/acc_26x34_row.md
Name: acc_26x34_row

Overview:
- Streaming row accumulator directly downstream of the 26x34 DSP multiplier.
- Consumes the stream of 60-bit partial products A*B_i. A is 26-bit. B_i are consecutive 34-bit limbs of a wide operand B, least-significant limb first.
- Produces the full row product C = sum(P_i << 34*i), of width 26+34*NUM_LIMBS.
- Carry-propagating shift-accumulate: one 34-bit limb is finalised per accepted product, so no wide adder is needed.

Parameters:
- NUM_LIMBS, 4, number of 34-bit B limbs per row; legal range 2..16.
- FF_OUT, 1, 1 = registered out_c/out_valid; 0 = combinational from the last-product cycle.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low (rst = 0 resets on the next clk edge).
- in_valid  in  1  in_p carries a product this cycle; no backpressure, block is always ready.
- in_p  in  60  partial product A*B_i.
- in_clr  in  1  abandon the current row; the next accepted product is limb 0.
- out_valid  out  1  one-cycle pulse, out_c holds a completed row.
- out_c  out  26+34*NUM_LIMBS  row result; holds its value until the next completion.
- busy  out  1  1 while a row is partially accumulated (limb counter != 0).

Behaviour:
- State: limb counter k (0..NUM_LIMBS-1), carry register cr[25:0], limb shift register lo[34*(NUM_LIMBS-1)-1:0], result register.
- Reset (rst = 0): k = 0, cr = 0, lo = 0, out_valid = 0, out_c = 0, busy = 0.
- Per accepted product (in_valid = 1):
  - s = in_p + (k == 0 ? 0 : cr), 60-bit.
  - Overflow-free: max product (2^26-1)(2^34-1) plus (2^26-1) < 2^60.
- If k < NUM_LIMBS-1:
  - lo shifts right by 34 and s[33:0] enters at the top.
  - cr <= s[59:34]; k <= k+1.
- If k == NUM_LIMBS-1 (last limb):
  - result <= {s[59:0], lo}; out_valid pulses.
  - k <= 0; cr <= 0.
- Latency:
  - FF_OUT = 1: out_valid is high exactly one cycle after the last product's in_valid cycle.
  - FF_OUT = 0: out_valid is high in the same cycle, and out_c is driven from s and lo.
- in_valid = 0: all state holds (gaps are allowed anywhere in a row); out_valid = 0.
- Back-to-back rows at throughput 1 are supported with no bubble. Limb 0 of row r+1 may arrive the cycle after the last limb of row r.
- in_clr = 1 with in_valid = 0: k <= 0, cr <= 0; no out_valid; out_c unchanged.
- in_clr = 1 with in_valid = 1: the current row is discarded and this product is accepted as limb 0 of a new row (k <= 1, or completion if NUM_LIMBS == 1, which is illegal).
- Reset mid-row: the partial row is lost and no out_valid is produced.
- Reset in the same cycle as a last limb: reset wins and out_valid stays 0.
- busy = (k != 0).
- No X propagation: out_c changes only on completion or reset.

Decomposition:
- Shared package holds:
  - constants LIMB_W = 34, A_W = 26, P_W = 60;
  - a function computing C width = A_W + LIMB_W*NUM_LIMBS.
- The multiplier pipeline uses the same package constants.
- One sub-module is natural: acc_26x34_cstep. It is combinational and computes s = p + cr, then splits s into limb[33:0] and carry[25:0].
- The counter, shift register and result register stay in the top.

Test Plan (NUM_LIMBS = 4, FF_OUT = 1, C width 162):
- Products 1, 2, 3, 4 on consecutive cycles -> one cycle after the 4th, out_valid = 1 and out_c = 1 + 2·2^34 + 3·2^68 + 4·2^102; busy is 1 during limbs 1-3.
- Four products of (2^26-1)(2^34-1) -> out_c = (2^26-1)(2^136-1), which exercises full carry propagation every step.
- Products 5, 6, 7, 8 with 0-3 idle cycles inserted between each -> same result as gap-free; exactly one out_valid pulse.
- Two rows back-to-back (1, 2, 3, 4 then 9, 9, 9, 9) with no gap -> two out_valid pulses 4 cycles apart; second out_c = 9·(1 + 2^34 + 2^68 + 2^102); no carry leaks from row 1.
- Two products, then in_clr with in_valid on product 7, then 1, 1, 1 -> out_c = 7 + 2^34 + 2^68 + 2^102.
- Two products, then rst = 0 for one cycle, then 1, 2, 3, 4 -> no out_valid for the aborted row; outputs 0 during reset; result as in scenario 1.
